pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Sequences the board rPLL and the system reset. Runs on the free-running
//  27 MHz reference clock (the PLL input), pulses the PLL RESET pin, waits
//  for LOCK, qualifies it as stable, then releases the system reset. Loss of
//  lock, lock timeout or a software request restarts the sequence. sys_rst_n
//  is re-synchronised into the PLL clkout domain by its consumer.
// PARAMETERS
//  RST_CYCLES     16     cycles pll_reset is held high per attempt (>=1)
//  LOCK_TIMEOUT   65535  max cycles in WAIT_LOCK before retrying (>=1)
//  STABLE_CYCLES  1024   consecutive synced-lock-high cycles needed (>=1)
//  LOSS_CYCLES    4      consecutive lock-low cycles = loss (filter only)
//  CNT_W          17     shared counter width; every cycle param < 2**CNT_W
//  RETRY_W        4      width of saturating retry counter
// PORTS
//  clk          in   1        reference clock (27 MHz, never gated)
//  rst_n        in   1        asynchronous active-low reset
//  pll_lock     in   1        rPLL LOCK, asynchronous to clk
//  sw_rst_req   in   1        one-cycle pulse: restart full sequence
//  pll_reset    out  1        drives rPLL RESET, active high
//  sys_rst_n    out  1        system reset, active low
//  pll_ok       out  1        high only in RUN
//  retry_cnt    out  RETRY_W  number of lock timeouts, saturates at all-ones
//  state        out  2        00 PLL_RST, 01 WAIT_LOCK, 10 STABLE, 11 RUN
// BEHAVIOUR
//  - Reset (rst_n=0): state=PLL_RST, counter=0, pll_reset=1, sys_rst_n=0,
//    pll_ok=0, retry_cnt=0, lock synchroniser cleared. All outputs registered.
//  - pll_lock passes a 2-FF synchroniser -> lock_s; 2-cycle input latency.
//  - PLL_RST: pll_reset=1; counter counts 0..RST_CYCLES-1; at terminal count
//    -> WAIT_LOCK, counter=0. pll_reset high for exactly RST_CYCLES cycles.
//  - WAIT_LOCK: pll_reset=0. lock_s=1 -> STABLE, counter=0. Else counter
//    reaching LOCK_TIMEOUT-1 -> PLL_RST, retry_cnt+1 (saturating).
//  - STABLE: lock_s=0 -> WAIT_LOCK, counter=0 (timeout restarts; no retry
//    increment). lock_s=1 for STABLE_CYCLES consecutive cycles -> RUN.
//  - RUN: sys_rst_n=1, pll_ok=1 registered on entry cycle. Lock loss (see
//    CONFIGURATION) -> PLL_RST: sys_rst_n=0 and pll_ok=0 on the same edge
//    that enters PLL_RST. retry_cnt unchanged.
//  - sw_rst_req=1 in any state -> PLL_RST, counter=0; priority over every
//    other transition that cycle. retry_cnt not cleared (only rst_n clears).
//  - sys_rst_n=0 in every state except RUN; pll_reset=1 only in PLL_RST.
//  - Counter never wraps: cleared on every state entry, only compared to
//    terminal values; lock_s toggling resets qualification, not retry_cnt.
//  - rst_n asserted mid-sequence: immediate return to reset values above.
// CONFIGURATION
//  PLL_SEQ_LOSS_FILTER_EN defined: in RUN, loss = lock_s low for LOSS_CYCLES
//    consecutive cycles; any high sample clears the low-run counter.
//  Not defined: loss = a single lock_s low sample in RUN; LOSS_CYCLES unused.
//  Filter affects RUN only; STABLE always rejects on a single low sample.
// TESTING (bench params RST_CYCLES=4 LOCK_TIMEOUT=20 STABLE_CYCLES=8 LOSS_CYCLES=3)
//  1 Release rst_n, pll_lock=1 constant -> pll_reset high 4 cycles, RUN and
//    sys_rst_n=1 at 4+2(sync)+8 cycles (+/-1 per documented edges), retry=0.
//  2 pll_lock=0 forever -> PLL_RST re-entered every 4+20 cycles; retry_cnt
//    counts 1..15 then holds 15; sys_rst_n never rises.
//  3 In STABLE drop pll_lock 1 cycle at count 5 -> back to WAIT_LOCK, RUN
//    reached only after 8 further consecutive high cycles.
//  4 In RUN, 2-cycle lock drop: filter EN -> stays RUN; filter off -> sys_rst_n
//    falls, pll_reset pulses 4 cycles. 3-cycle drop with EN -> restart.
//  5 sw_rst_req pulse in RUN and in WAIT_LOCK -> PLL_RST next edge, counter 0,
//    retry_cnt unchanged; same-cycle timeout still yields PLL_RST, no increment.
//  6 Assert rst_n mid-STABLE -> outputs immediately at reset values, retry=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Sequences rPLL RESET -> LOCK wait -> lock qualification -> system reset release on the reference clock.
// Latency: all outputs registered; pll_lock seen 2 cycles late through the synchroniser.
// Backpressure: none; sw_rst_req always wins. Build with PLL_SEQ_LOSS_FILTER_EN to debounce lock loss in RUN.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOSS_CYCLES   = 4,
    parameter int CNT_W         = 17,
    parameter int RETRY_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock,
    input  logic               sw_rst_req,
    output logic               pll_reset,
    output logic               sys_rst_n,
    output logic               pll_ok,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'b00,
        S_WAIT_LOCK = 2'b01,
        S_STABLE    = 2'b10,
        S_RUN       = 2'b11
    } state_t;

`ifdef PLL_SEQ_LOSS_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] RST_TERM     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_TERM  = CNT_W'(STABLE_CYCLES - 1);
    // Without the filter a single low sample in RUN is already a loss.
    localparam logic [CNT_W-1:0] LOSS_TERM    = FILTER_EN ? CNT_W'(LOSS_CYCLES - 1) : {CNT_W{1'b0}};

    logic               r_sync1;
    logic               r_sync2;
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [RETRY_W-1:0] r_retry;
    logic               r_pll_reset;
    logic               r_sys_rst_n;
    logic               r_pll_ok;

    logic               w_lock_s;
    logic               w_retry_sat;

    assign w_lock_s    = r_sync2;
    assign w_retry_sat = &r_retry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_lock;
            r_sync2 <= r_sync1;
        end
    end

    // In RUN the shared counter tracks the current run of low lock samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_pll_ok    <= 1'b0;
        end else if (sw_rst_req) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_pll_ok    <= 1'b0;
        end else begin
            case (r_state)
                S_PLL_RST: begin
                    if (r_cnt == RST_TERM) begin
                        r_state     <= S_WAIT_LOCK;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        r_state <= S_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == TIMEOUT_TERM) begin
                        r_state     <= S_PLL_RST;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b1;
                        if (!w_retry_sat) begin
                            r_retry <= r_retry + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!w_lock_s) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == STABLE_TERM) begin
                        r_state     <= S_RUN;
                        r_cnt       <= '0;
                        r_sys_rst_n <= 1'b1;
                        r_pll_ok    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_lock_s) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LOSS_TERM) begin
                        r_state     <= S_PLL_RST;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b1;
                        r_sys_rst_n <= 1'b0;
                        r_pll_ok    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_PLL_RST;
                    r_cnt       <= '0;
                    r_pll_reset <= 1'b1;
                    r_sys_rst_n <= 1'b0;
                    r_pll_ok    <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset = r_pll_reset;
    assign sys_rst_n = r_sys_rst_n;
    assign pll_ok    = r_pll_ok;
    assign retry_cnt = r_retry;
    assign state     = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: per-cycle vector table plus lock-loss, timeout and async-reset sequences.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       sw_rst_req;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       pll_ok;
    logic [3:0] retry_cnt;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    pll_reset_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .LOSS_CYCLES  (3),
        .CNT_W        (17),
        .RETRY_W      (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .sw_rst_req(sw_rst_req),
        .pll_reset (pll_reset),
        .sys_rst_n (sys_rst_n),
        .pll_ok    (pll_ok),
        .retry_cnt (retry_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       lock;
        logic       sw;
        int         reps;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [8:0] ex(input logic [1:0] st, input logic pr, input logic srn,
                                      input logic ok, input logic [3:0] rt);
        return {st, pr, srn, ok, rt};
    endfunction

    task automatic add(input logic r, input logic l, input logic s, input int n, input logic [8:0] e);
        vec_t v;
        v.rst_n = r;
        v.lock  = l;
        v.sw    = s;
        v.reps  = n;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int idx, input logic [8:0] e);
        logic [8:0] act;
        act = {state, pll_reset, sys_rst_n, pll_ok, retry_cnt};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s[%0d]: got st=%0d pll_reset=%0b sys_rst_n=%0b pll_ok=%0b retry=%0d, want st=%0d pll_reset=%0b sys_rst_n=%0b pll_ok=%0b retry=%0d",
                     nm, idx, act[8:7], act[6], act[5], act[4], act[3:0],
                     e[8:7], e[6], e[5], e[4], e[3:0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time limit, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;
        rst_n      = 1'b0;
        pll_lock   = 1'b1;
        sw_rst_req = 1'b0;

        // Power-up with lock held high: reset pulse, sync, qualification, RUN.
        add(0, 1, 0, 2, ex(2'd0, 1, 0, 0, 0));
        add(1, 1, 0, 3, ex(2'd0, 1, 0, 0, 0));
        add(1, 1, 0, 1, ex(2'd1, 0, 0, 0, 0));
        add(1, 1, 0, 8, ex(2'd2, 0, 0, 0, 0));
        add(1, 1, 0, 4, ex(2'd3, 0, 1, 1, 0));
        // Two-cycle lock drop in RUN.
        add(1, 0, 0, 2, ex(2'd3, 0, 1, 1, 0));
`ifdef PLL_SEQ_LOSS_FILTER_EN
        add(1, 1, 0, 6, ex(2'd3, 0, 1, 1, 0));
        add(1, 0, 0, 3, ex(2'd3, 0, 1, 1, 0));
        add(1, 1, 0, 1, ex(2'd3, 0, 1, 1, 0));
        add(1, 1, 0, 4, ex(2'd0, 1, 0, 0, 0));
        add(1, 1, 0, 1, ex(2'd1, 0, 0, 0, 0));
        add(1, 1, 0, 8, ex(2'd2, 0, 0, 0, 0));
        add(1, 1, 0, 2, ex(2'd3, 0, 1, 1, 0));
`else
        add(1, 1, 0, 4, ex(2'd0, 1, 0, 0, 0));
        add(1, 1, 0, 1, ex(2'd1, 0, 0, 0, 0));
        add(1, 1, 0, 8, ex(2'd2, 0, 0, 0, 0));
        add(1, 1, 0, 2, ex(2'd3, 0, 1, 1, 0));
`endif
        // Software restart from RUN, then a one-cycle glitch seen in STABLE at count 5.
        add(1, 1, 1, 1, ex(2'd0, 1, 0, 0, 0));
        add(1, 1, 0, 3, ex(2'd0, 1, 0, 0, 0));
        add(1, 1, 0, 1, ex(2'd1, 0, 0, 0, 0));
        add(1, 1, 0, 4, ex(2'd2, 0, 0, 0, 0));
        add(1, 0, 0, 1, ex(2'd2, 0, 0, 0, 0));
        add(1, 1, 0, 1, ex(2'd2, 0, 0, 0, 0));
        add(1, 1, 0, 1, ex(2'd1, 0, 0, 0, 0));
        add(1, 1, 0, 8, ex(2'd2, 0, 0, 0, 0));
        add(1, 1, 0, 2, ex(2'd3, 0, 1, 1, 0));

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                rst_n      = vecs[i].rst_n;
                pll_lock   = vecs[i].lock;
                sw_rst_req = vecs[i].sw;
                tick();
                check("vec", i, vecs[i].exp);
            end
        end

        // Lock never arrives; sw request lands on the timeout cycle of the first attempt.
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        tick();
        tick();
        check("nolock_rst", 0, ex(2'd0, 1, 0, 0, 0));
        rst_n = 1'b1;
        for (int p = 0; p < 23; p++) begin
            logic [1:0] st;
            tick();
            st = (p < 3) ? 2'd0 : 2'd1;
            check("first_attempt", p, ex(st, st == 2'd0, 0, 0, 0));
        end
        sw_rst_req = 1'b1;
        tick();
        check("sw_on_timeout", 0, ex(2'd0, 1, 0, 0, 0));
        sw_rst_req = 1'b0;
        for (int a = 0; a < 17; a++) begin
            for (int p = 0; p < 24; p++) begin
                logic [1:0] st;
                int         n;
                tick();
                st = (p < 3 || p == 23) ? 2'd0 : 2'd1;
                n  = (p == 23) ? a + 1 : a;
                if (n > 15) n = 15;
                check("retry_loop", a * 24 + p, ex(st, st == 2'd0, 0, 0, 4'(n)));
            end
        end

        // Lock returns; assert rst_n asynchronously while qualifying.
        pll_lock = 1'b1;
        found    = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (state == 2'd2) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_stable: got state=%0d after 40 cycles, want 2", state);
        end
        repeat (3) tick();
        check("stable_pre_rst", 0, ex(2'd2, 0, 0, 0, 15));
        #2 rst_n = 1'b0;
        #1 check("async_rst", 0, ex(2'd0, 1, 0, 0, 0));
        tick();
        check("async_rst_hold", 0, ex(2'd0, 1, 0, 0, 0));
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst", k, ex(2'd0, 1, 0, 0, 0));
        end
        tick();
        check("post_rst_wait", 0, ex(2'd1, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
